mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, operand/result width; all other widths are fixed at 32.
REQ-002 clk  input  1  single clock; every sequential element SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin an operation; accepted only while busy=0.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with an accepted start.
REQ-006 rs_data, rt_data  input  32 each  operands from register-file read ports 1/2 (rs = multiplicand/dividend, rt = multiplier/divisor).
REQ-007 hi_we, lo_we  input  1 each  MTHI/MTLO write strobes.
REQ-008 wdata  input  32  MTHI/MTLO write value.
REQ-009 busy  output  1  operation in progress; the core SHALL stall on it.
REQ-010 done  output  1  one-cycle pulse when hi/lo take a new result.
REQ-011 hi, lo  output  32 each  architectural HI/LO, read combinationally by MFHI/MFLO.

Function
REQ-012 FSM states SHALL be IDLE and RUN; IDLE->RUN on start while busy=0; RUN->IDLE after the 32nd iteration.
REQ-013 busy SHALL be high exactly in RUN: when start is accepted at edge k, busy is high from edge k to edge k+32.
REQ-014 Exactly 32 iterations, one bit per cycle (shift-add multiply, restoring divide); the result SHALL be written to hi/lo at edge k+32, busy falls there, and done is high for exactly the cycle after edge k+32.
REQ-015 Operands and op SHALL be latched at acceptance; later changes to rs_data/rt_data/op have no effect.
REQ-016 MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product.
REQ-017 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-018 Signed operations SHALL run on magnitudes, with sign correction applied in the write-back cycle.
REQ-019 Divide by zero (rt=0), DIV or DIVU: lo = 32'hFFFFFFFF, hi = rs; full 32-cycle latency still applies.
REQ-020 DIV 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 hi_we/lo_we while busy=0 SHALL write wdata into hi/lo at the next edge; both together write both.
REQ-023 hi_we/lo_we while busy=1 SHALL be ignored.
REQ-024 start together with hi_we or lo_we in IDLE: start is accepted and the write is ignored.
REQ-025 hi/lo SHALL hold their value during RUN and change only at write-back, at MTHI/MTLO, or on reset.
REQ-026 done SHALL never assert without a preceding accepted start.

Reset
REQ-027 With rst=1 at an edge: state=IDLE, busy=0, done=0, hi=0, lo=0, and the internal accumulator, counter and latched operands are cleared.
REQ-028 rst SHALL take priority over start, hi_we and lo_we.
REQ-029 rst during RUN SHALL abort the operation: no write-back, no done pulse.

Structure
REQ-030 Shared package mdu_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum and the iteration count constant (32).
REQ-031 One combinational sub-module, mdu_sign_fix, SHALL provide operand absolute value and result negation for the signed ops.
REQ-032 The iteration counter SHALL be 6 bits wide.
REQ-033 The datapath SHALL be a single 64-bit shift register plus a 33-bit adder/subtractor; no array multiplier.

Verification
REQ-034 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> after 32 busy cycles: hi=32'hFFFFFFFE, lo=32'h00000001, done for 1 cycle.
REQ-035 MULT -3 x 5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-036 DIVU 100 / 0 -> lo=32'hFFFFFFFF, hi=100; DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
REQ-037 Second start and hi_we during RUN -> both ignored, result of the first op only, busy length unchanged.
REQ-038 rst asserted at iteration 10 of DIVU 9/3 -> busy=0, done never pulses, hi=lo=0 on the next cycle.
REQ-039 IDLE hi_we=1, lo_we=1, wdata=32'h1234 -> both hi and lo read 32'h1234 next cycle; with start asserted in the same cycle -> the write is dropped and the op proceeds.

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the iterative multiply/divide unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int unsigned ITER_COUNT = 32;
    localparam int          CNT_W      = 6;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_sign_fix.sv
// ============================================================================
// Module      : mdu_sign_fix
// Description : Operand magnitudes on entry and result negation on write-back.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mdu_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic                signed_i,
    input  logic [XLEN-1:0]     rs_i,
    input  logic [XLEN-1:0]     rt_i,
    output logic                rs_neg_o,
    output logic                rt_neg_o,
    output logic [XLEN-1:0]     rs_abs_o,
    output logic [XLEN-1:0]     rt_abs_o,
    input  logic [2*XLEN-1:0]   res_i,
    input  logic                neg_full_i,
    input  logic                neg_hi_i,
    input  logic                neg_lo_i,
    output logic [2*XLEN-1:0]   res_o
);

    assign rs_neg_o = signed_i & rs_i[XLEN-1];
    assign rt_neg_o = signed_i & rt_i[XLEN-1];
    assign rs_abs_o = rs_neg_o ? ({XLEN{1'b0}} - rs_i) : rs_i;
    assign rt_abs_o = rt_neg_o ? ({XLEN{1'b0}} - rt_i) : rt_i;

    // A product negates as one 64-bit value; quotient and remainder negate independently.
    always_comb begin
        res_o = res_i;
        if (neg_full_i) begin
            res_o = {(2*XLEN){1'b0}} - res_i;
        end else begin
            if (neg_hi_i) res_o[2*XLEN-1:XLEN] = {XLEN{1'b0}} - res_i[2*XLEN-1:XLEN];
            if (neg_lo_i) res_o[XLEN-1:0]      = {XLEN{1'b0}} - res_i[XLEN-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : 32-cycle shift-add multiplier / restoring divider with HI/LO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [XLEN-1:0]   rs_data_i,
    input  logic [XLEN-1:0]   rt_data_i,
    input  logic              hi_we_i,
    input  logic              lo_we_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [XLEN-1:0]   hi_o,
    output logic [XLEN-1:0]   lo_o
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [1:0]          op_q, op_d;
    logic                quo_neg_q, quo_neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic                dz_q, dz_d;
    logic [XLEN-1:0]     rs_q, rs_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic                done_q, done_d;

    logic                w_rs_neg, w_rt_neg;
    logic [XLEN-1:0]     w_rs_abs, w_rt_abs;
    logic                w_div;
    logic [XLEN:0]       w_add_a, w_add_b;
    logic [XLEN+1:0]     w_sum;
    logic [2*XLEN-1:0]   w_acc_step;
    logic [2*XLEN-1:0]   w_res;

    mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .signed_i   (op_is_signed(op_i)),
        .rs_i       (rs_data_i),
        .rt_i       (rt_data_i),
        .rs_neg_o   (w_rs_neg),
        .rt_neg_o   (w_rt_neg),
        .rs_abs_o   (w_rs_abs),
        .rt_abs_o   (w_rt_abs),
        .res_i      (w_acc_step),
        .neg_full_i (!w_div && quo_neg_q),
        .neg_hi_i   (w_div && rem_neg_q),
        .neg_lo_i   (w_div && quo_neg_q),
        .res_o      (w_res)
    );

    // One shared 33-bit adder: add for multiply, subtract (carry-out = no borrow) for divide.
    assign w_div   = op_is_div(op_q);
    assign w_add_a = w_div ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
    assign w_add_b = w_div ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
    assign w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, w_div};

    always_comb begin
        if (w_div) begin
            w_acc_step = w_sum[XLEN+1] ? {w_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                                       : {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            w_acc_step = acc_q[0] ? {w_sum[XLEN:0], acc_q[XLEN-1:1]}
                                  : {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        rs_d      = rs_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    op_d      = op_i;
                    acc_d     = {{XLEN{1'b0}}, op_is_div(op_i) ? w_rs_abs : w_rt_abs};
                    opnd_d    = op_is_div(op_i) ? w_rt_abs : w_rs_abs;
                    quo_neg_d = w_rs_neg ^ w_rt_neg;
                    rem_neg_d = w_rs_neg;
                    dz_d      = (rt_data_i == '0);
                    rs_d      = rs_data_i;
                end else begin
                    if (hi_we_i) hi_d = wdata_i;
                    if (lo_we_i) lo_d = wdata_i;
                end
            end
            RUN: begin
                acc_d = w_acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (w_div && dz_q) begin
                        hi_d = rs_q;
                        lo_d = '1;
                    end else begin
                        {hi_d, lo_d} = w_res;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= OP_MULT;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            rs_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            rs_q      <= rs_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = (state_q == RUN);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Scoreboard bench for mult_div_unit against an arithmetic model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs_data_i = '0;
    logic [31:0] rt_data_i = '0;
    logic        hi_we_i = 1'b0;
    logic        lo_we_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    mult_div_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .rs_data_i (rs_data_i),
        .rt_data_i (rt_data_i),
        .hi_we_i   (hi_we_i),
        .lo_we_i   (lo_we_i),
        .wdata_i   (wdata_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Encodings: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU. Result packed as {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: res = 64'(sa * sb);
            2'd1: res = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("result_hi", 64'(hi_o), 64'(e[63:32]));
                    chk("result_lo", 64'(lo_o), 64'(e[31:0]));
                end
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input bit disturb, input bit with_wr);
        logic [63:0] e;
        int n;
        bit stable;
        e = model(op, rs, rt);
        start_i = 1'b1;
        op_i = op;
        rs_data_i = rs;
        rt_data_i = rt;
        if (with_wr) begin
            hi_we_i = 1'b1;
            lo_we_i = 1'b1;
            wdata_i = $urandom;
        end
        @(posedge clk); #1;
        exp_q.push_back(e);
        start_i = 1'b0;
        hi_we_i = 1'b0;
        lo_we_i = 1'b0;
        op_i = 2'($urandom_range(0, 3));
        rs_data_i = $urandom;
        rt_data_i = $urandom;
        chk("busy_after_accept", 64'(busy_o), 64'd1);
        n = 0;
        stable = 1'b1;
        while (busy_o === 1'b1 && n < 100) begin
            if (hi_o !== hi_m || lo_o !== lo_m) stable = 1'b0;
            if (disturb && n == 5) begin
                start_i = 1'b1;
                op_i = 2'($urandom_range(0, 3));
                rs_data_i = $urandom;
                rt_data_i = $urandom;
                hi_we_i = 1'b1;
                lo_we_i = 1'b1;
                wdata_i = $urandom;
            end else begin
                start_i = 1'b0;
                hi_we_i = 1'b0;
                lo_we_i = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start_i = 1'b0;
        hi_we_i = 1'b0;
        lo_we_i = 1'b0;
        chk("busy_cycles", 64'(n), 64'd32);
        chk("hold_during_run", 64'(stable), 64'd1);
        hi_m = e[63:32];
        lo_m = e[31:0];
    endtask

    task automatic mt(input bit hw, input bit lw, input logic [31:0] wd);
        hi_we_i = hw;
        lo_we_i = lw;
        wdata_i = wd;
        @(posedge clk); #1;
        hi_we_i = 1'b0;
        lo_we_i = 1'b0;
        if (hw) hi_m = wd;
        if (lw) lo_m = wd;
        chk("mt_hi", 64'(hi_o), 64'(hi_m));
        chk("mt_lo", 64'(lo_o), 64'(lo_m));
    endtask

    task automatic reset_mid_op();
        start_i = 1'b1;
        op_i = 2'd3;
        rs_data_i = 32'd9;
        rt_data_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        hi_m = '0;
        lo_m = '0;
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_hi", 64'(hi_o), 64'd0);
        chk("abort_lo", 64'(lo_o), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_stays_idle", 64'(busy_o), 64'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_hi", 64'(hi_o), 64'd0);
        chk("reset_lo", 64'(lo_o), 64'd0);
        rst = 1'b0;

        mt(1'b1, 1'b1, 32'h0000_1234);
        mt(1'b1, 1'b0, $urandom);
        mt(1'b0, 1'b1, $urandom);

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'd0, -32'sd3, 32'd5, 1'b0, 1'b0);
        run_op(2'd2, -32'sd7, 32'd2, 1'b0, 1'b0);
        run_op(2'd3, 32'd100, 32'd0, 1'b0, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'd2, -32'sd5, 32'd0, 1'b0, 1'b0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(2'd1, $urandom, $urandom, 1'b1, 1'b0);
        run_op(2'd2, $urandom, 32'd7, 1'b0, 1'b1);
        reset_mid_op();

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin
                    a = 32'($urandom_range(0, 40)) - 32'd20;
                    b = 32'($urandom_range(0, 40)) - 32'd20;
                end
                default: ;
            endcase
            run_op(op, a, b, 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) mt($urandom_range(0, 1) == 1, 1'b1, $urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
